// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
//
// Microprogram sequencer. Owns the micro-PC (upc), addresses the 256x20
// microcode ROM, captures each returned microword in the micro-instruction
// register (uir) and presents its 7-bit control field to the datapath.
//
// Every microword takes one FETCH cycle and one or more EXEC cycles. At the
// end of the last EXEC cycle the next micro-address is chosen by the word's
// mode field: increment, jump, conditional jump on datapath flags, or
// dispatch on the macro opcode. A word with its halt bit set parks the
// sequencer in HALT until the next start.
//
// Microword layout:
//   [19]    halt
//   [18:17] mode   00 inc, 01 jump, 10 cond jump, 11 dispatch
//   [16:15] cond   0 Z, 1 C, 2 N, 3 !Z
//   [14:7]  target
//   [6:0]   control
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start_i       begin execution at START_ADDR (IDLE or HALT only)
//   opcode_i[3:0] macro opcode used by dispatch
//   flags_i[2:0]  datapath flags {N,C,Z}, sampled at the end of EXEC
//   wait_i        datapath not ready; holds the current microword in EXEC
//   rom_addr_o    micro-address to ROM (always equals upc)
//   rom_data_i    microword returned by the ROM (combinational)
//   ctrl_o        datapath control field, zero outside EXEC
//   ctrl_valid_o  high while in EXEC
//   busy_o        high in FETCH or EXEC
//   halted_o      high in HALT
// -----------------------------------------------------------------------------
module micro_sequencer #(
    parameter logic [7:0] START_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [3:0]  opcode_i,
    input  logic [2:0]  flags_i,
    input  logic        wait_i,
    output logic [7:0]  rom_addr_o,
    input  logic [19:0] rom_data_i,
    output logic [6:0]  ctrl_o,
    output logic        ctrl_valid_o,
    output logic        busy_o,
    output logic        halted_o
);

    localparam int HALT_BIT = 19;

    localparam logic [1:0] MODE_INC  = 2'b00;
    localparam logic [1:0] MODE_JMP  = 2'b01;
    localparam logic [1:0] MODE_CJMP = 2'b10;
    localparam logic [1:0] MODE_DISP = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t      state;
    logic [7:0]  upc;
    logic [19:0] uir;
    logic [7:0]  next_upc;

    // Condition select over the datapath flags {N,C,Z}.
    function automatic logic cond_true(input logic [1:0] sel,
                                       input logic [2:0] flags);
        logic r;
        case (sel)
            2'd0:    r = flags[0];
            2'd1:    r = flags[1];
            2'd2:    r = flags[2];
            default: r = ~flags[0];
        endcase
        return r;
    endfunction

    // Next micro-address for the word held in uir. The increment wraps
    // naturally at 8 bits (FF -> 00).
    function automatic logic [7:0] calc_next(input logic [19:0] word,
                                             input logic [7:0]  pc,
                                             input logic [2:0]  flags,
                                             input logic [3:0]  opcode);
        logic [7:0] inc;
        logic [7:0] tgt;
        logic [7:0] r;
        inc = pc + 8'd1;
        tgt = word[14:7];
        case (word[18:17])
            MODE_INC:  r = inc;
            MODE_JMP:  r = tgt;
            MODE_CJMP: r = cond_true(word[16:15], flags) ? tgt : inc;
            MODE_DISP: r = {opcode, 4'b0000};
            default:   r = inc;
        endcase
        return r;
    endfunction

    assign next_upc   = calc_next(uir, upc, flags_i, opcode_i);
    assign rom_addr_o = upc;

    // All outputs other than the ROM address are registered so that they
    // only ever change just after a clock edge (or on reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            upc          <= START_ADDR;
            uir          <= '0;
            ctrl_o       <= '0;
            ctrl_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            halted_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        upc    <= START_ADDR;
                        busy_o <= 1'b1;
                        state  <= FETCH;
                    end
                end

                // ROM address has been stable for the whole cycle; capture
                // the word and expose its control field in the next cycle.
                FETCH: begin
                    uir          <= rom_data_i;
                    ctrl_o       <= rom_data_i[6:0];
                    ctrl_valid_o <= 1'b1;
                    state        <= EXEC;
                end

                // wait_i holds everything; the final EXEC cycle is the one
                // in which wait_i is low, and it decides where to go next.
                EXEC: begin
                    if (!wait_i) begin
                        ctrl_o       <= '0;
                        ctrl_valid_o <= 1'b0;
                        if (uir[HALT_BIT]) begin
                            busy_o   <= 1'b0;
                            halted_o <= 1'b1;
                            state    <= HALT;
                        end else begin
                            upc   <= next_upc;
                            state <= FETCH;
                        end
                    end
                end

                HALT: begin
                    if (start_i) begin
                        upc      <= START_ADDR;
                        busy_o   <= 1'b1;
                        halted_o <= 1'b0;
                        state    <= FETCH;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [3:0]  opcode_i;
    logic [2:0]  flags_i;
    logic        wait_i;
    logic [7:0]  rom_addr;
    logic [19:0] rom_data;
    logic [6:0]  ctrl;
    logic        ctrl_valid;
    logic        busy;
    logic        halted;

    logic [19:0] rom [256];

    int checks;
    int errors;
    int exp_addr;

    micro_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .opcode_i     (opcode_i),
        .flags_i      (flags_i),
        .wait_i       (wait_i),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .ctrl_o       (ctrl),
        .ctrl_valid_o (ctrl_valid),
        .busy_o       (busy),
        .halted_o     (halted)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] mk(input int h, input int m, input int c,
                                       input int t, input int ct);
        return {1'(h), 2'(m), 2'(c), 8'(t), 7'(ct)};
    endfunction

    // Reference next-address rule, in plain arithmetic on the word value.
    function automatic int model_next(input int a, input int w,
                                      input int f, input int o);
        int mode, cs, tgt, inc, z, c, n, ok;
        mode = (w >> 17) & 3;
        cs   = (w >> 15) & 3;
        tgt  = (w >> 7) & 255;
        inc  = (a + 1) % 256;
        z = f % 2; c = (f / 2) % 2; n = (f / 4) % 2;
        ok = (cs == 0) ? z : (cs == 1) ? c : (cs == 2) ? n : 1 - z;
        case (mode)
            0: return inc;
            1: return tgt;
            2: return ok ? tgt : inc;
            default: return o * 16;
        endcase
    endfunction

    function automatic int rbit();
        return ($urandom_range(0, 3) == 0) ? 1 : 0;
    endfunction

    // Called at the negedge inside an IDLE or HALT cycle.
    task automatic start_run();
        chk("idle_ctrl", int'(ctrl), 0);
        chk("idle_vld", int'(ctrl_valid), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_addr", int'(rom_addr), exp_addr);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        exp_addr = 0;
    endtask

    // Called at the negedge of a FETCH cycle; runs one microword to the
    // negedge of the following FETCH (or HALT) cycle.
    task automatic step_word(input int waits, input int fl, input int op,
                             output bit hlt);
        int w, f, o;
        w = int'(rom[exp_addr]);
        f = 0; o = 0;
        chk("fetch_busy", int'(busy), 1);
        chk("fetch_vld", int'(ctrl_valid), 0);
        chk("fetch_ctrl", int'(ctrl), 0);
        chk("fetch_halted", int'(halted), 0);
        chk("fetch_addr", int'(rom_addr), exp_addr);
        start_i = 1'(rbit());
        @(negedge clk);
        for (int i = 0; i <= waits; i++) begin
            chk("exec_ctrl", int'(ctrl), w % 128);
            chk("exec_vld", int'(ctrl_valid), 1);
            chk("exec_busy", int'(busy), 1);
            chk("exec_halted", int'(halted), 0);
            chk("exec_addr", int'(rom_addr), exp_addr);
            f = (i == waits && fl >= 0) ? fl : int'($urandom_range(0, 7));
            o = (i == waits && op >= 0) ? op : int'($urandom_range(0, 15));
            wait_i   = (i < waits);
            flags_i  = 3'(f);
            opcode_i = 4'(o);
            start_i  = 1'(rbit());
            @(negedge clk);
        end
        wait_i  = 1'b0;
        start_i = 1'b0;
        hlt = ((w >> 19) & 1) == 1;
        if (hlt) begin
            chk("halt_halted", int'(halted), 1);
            chk("halt_busy", int'(busy), 0);
            chk("halt_vld", int'(ctrl_valid), 0);
            chk("halt_ctrl", int'(ctrl), 0);
            chk("halt_addr", int'(rom_addr), exp_addr);
        end else begin
            exp_addr = model_next(exp_addr, w, f, o);
        end
    endtask

    // Reset asserted away from any clock edge; outputs must clear at once.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctrl", int'(ctrl), 0);
        chk("rst_vld", int'(ctrl_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_addr", int'(rom_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr = 0;
    endtask

    // From the negedge of a FETCH cycle: enter EXEC, then reset mid-cycle.
    task automatic mid_exec_reset();
        @(negedge clk);
        chk("pre_rst_vld", int'(ctrl_valid), 1);
        pulse_reset();
    endtask

    initial begin
        bit h;
        checks = 0; errors = 0; exp_addr = 0;
        rst_n = 1'b0; start_i = 1'b0; opcode_i = '0; flags_i = '0; wait_i = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = '0;

        @(negedge clk);
        chk("reset_addr", int'(rom_addr), 0);
        chk("reset_ctrl", int'(ctrl), 0);
        chk("reset_vld", int'(ctrl_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_halted", int'(halted), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Straight-line program ending in halt.
        rom[0] = mk(0, 0, 0, 0, 1);
        rom[1] = mk(0, 0, 0, 0, 2);
        rom[2] = mk(0, 0, 0, 0, 3);
        rom[3] = mk(1, 0, 0, 0, 4);
        start_run();
        for (int i = 0; i < 4; i++) step_word(0, -1, -1, h);
        chk("seq_halted", int'(h), 1);
        start_run();
        step_word(0, -1, -1, h);
        pulse_reset();

        // Jump to FF and wrap back to 00; reset in the middle of EXEC.
        rom[0]     = mk(0, 1, 0, 8'hFF, 5);
        rom[8'hFF] = mk(0, 0, 0, 0, 6);
        start_run();
        step_word(0, -1, -1, h);
        chk("jump_ff", exp_addr, 8'hFF);
        step_word(0, -1, -1, h);
        step_word(0, -1, -1, h);
        mid_exec_reset();

        // Conditional jump on Z, then on !Z.
        rom[0]     = mk(0, 2, 0, 8'h40, 7);
        rom[1]     = mk(1, 0, 0, 0, 9);
        rom[8'h40] = mk(1, 0, 0, 0, 8);
        start_run();
        step_word(0, 3'b001, -1, h);
        step_word(0, -1, -1, h);
        start_run();
        step_word(0, 3'b000, -1, h);
        step_word(0, -1, -1, h);
        rom[0] = mk(0, 2, 3, 8'h40, 7);
        start_run();
        step_word(0, 3'b110, -1, h);
        step_word(0, -1, -1, h);

        // Dispatch on opcode A.
        rom[0]     = mk(0, 3, 0, 0, 8'h11);
        rom[8'hA0] = mk(1, 0, 0, 0, 8'h12);
        start_run();
        step_word(0, -1, 4'hA, h);
        step_word(0, -1, -1, h);

        // Three wait cycles on one word.
        rom[0] = mk(0, 0, 0, 0, 8'h21);
        rom[1] = mk(1, 0, 0, 0, 8'h22);
        start_run();
        step_word(3, -1, -1, h);
        step_word(0, -1, -1, h);
        pulse_reset();

        // Random microprograms.
        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < 256; i++)
                rom[i] = mk(($urandom_range(0, 7) == 0) ? 1 : 0,
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 255)), int'($urandom_range(0, 127)));
            start_run();
            h = 1'b0;
            for (int n = 0; n < 30 && !h; n++)
                step_word(int'($urandom_range(0, 2)), -1, -1, h);
            if (!h) mid_exec_reset();
            else pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
